// File: rtl/vga_console_writer.sv
// ---------------------------------------------------------------------------
// vga_console_writer
//
// Takes a stream of bytes and turns it into single-cycle writes on the write
// port of the VGA character controller. It keeps a text cursor, so software
// or a UART sink can print text without working out memory addresses.
//
// Printable ASCII (0x20..0x7E) is written at the cursor, and the cursor then
// moves one column right. When it moves past the last column it goes to the
// start of the next row. It also handles these control codes:
//   0x0D CR : cursor to column 0, no write
//   0x0A LF : cursor to column 0 of the next row, then that row is blanked
//   0x08 BS : cursor one column left and a blank is written there
//   0x0C FF : cursor home and the whole screen is blanked
// Any other byte is consumed and ignored. Rows wrap from the last row back to
// row 0 (no scrolling). Every row that the cursor enters is blanked first.
//
// Ports (everything is in the clk_data domain):
//   clk_data    in   data clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   in_char holds a byte
//   in_char     in   ASCII byte or control code
//   in_ready    out  a byte can be accepted this cycle (IDLE only)
//   char_we     out  character-memory write strobe, one cycle per write
//   char_addr   out  {row[4:0], col[6:0]}
//   char_value  out  {24'h0, byte}
//   cursor_col  out  current cursor column
//   cursor_row  out  current cursor row
//   busy        out  high while a line or screen clear is running
// ---------------------------------------------------------------------------
module vga_console_writer #(
  parameter int          COLS           = 80,
  parameter int          ROWS           = 30,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0]  BLANK_CHAR     = 8'h20
) (
  input  logic        clk_data,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_char,
  output logic        in_ready,
  output logic        char_we,
  output logic [11:0] char_addr,
  output logic [31:0] char_value,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [2:0] RESET_WAIT = 3'd0;
  localparam logic [2:0] IDLE       = 3'd1;
  localparam logic [2:0] WRITE      = 3'd2;
  localparam logic [2:0] CLR_LINE   = 3'd3;
  localparam logic [2:0] CLR_SCREEN = 3'd4;

  localparam logic [6:0]  LAST_COL    = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW    = 5'(ROWS - 1);
  localparam logic [31:0] BLANK_VALUE = {24'h0, BLANK_CHAR};

  logic [2:0] state;

  // A printable character moves the cursor on when its write finishes. The
  // blank written by a backspace does not, because the cursor has already
  // moved back.
  logic       advance_after_write;

  logic       accept;
  logic       printable;
  logic [4:0] next_row;
  logic [4:0] addr_row;
  logic [6:0] addr_col;

  // The clear sequences use char_addr itself as their position counter.
  // The output is registered already, so no second counter is needed.
  assign addr_row = char_addr[11:7];
  assign addr_col = char_addr[6:0];

  // in_ready is a register that is high exactly while the FSM is in IDLE.
  // This makes it a valid accept qualifier with no extra decoding.
  assign accept = in_valid && in_ready;

  always_comb begin
    // NOTE: every always_comb output gets a value before any condition, so
    // no path through the block can leave a latch behind.
    printable = 1'b0;
    next_row  = cursor_row + 5'd1;
    if (in_char >= 8'h20 && in_char <= 8'h7E) begin
      printable = 1'b1;
    end
    if (cursor_row == LAST_ROW) begin
      next_row = '0;
    end
  end

  // All outputs are registered. Each branch below loads the output values
  // that belong to the state it enters, so the outputs and the state
  // register always describe the same cycle.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state               <= RESET_WAIT;
      advance_after_write <= 1'b0;
      in_ready            <= 1'b0;
      char_we             <= 1'b0;
      char_addr           <= '0;
      char_value          <= '0;
      cursor_col          <= '0;
      cursor_row          <= '0;
      busy                <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. This lets
      // a later branch override the default below without creating any
      // ordering hazard between registers.
      char_we <= 1'b0;

      case (state)
        RESET_WAIT: begin
          if (CLEAR_ON_RESET) begin
            state      <= CLR_SCREEN;
            busy       <= 1'b1;
            char_we    <= 1'b1;
            char_addr  <= '0;
            char_value <= BLANK_VALUE;
          end else begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end

        IDLE: begin
          if (accept) begin
            if (printable) begin
              state               <= WRITE;
              in_ready            <= 1'b0;
              advance_after_write <= 1'b1;
              char_we             <= 1'b1;
              char_addr           <= {cursor_row, cursor_col};
              char_value          <= {24'h0, in_char};
            end else begin
              case (in_char)
                8'h0D: begin
                  cursor_col <= '0;
                end

                8'h0A: begin
                  cursor_col <= '0;
                  cursor_row <= next_row;
                  state      <= CLR_LINE;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  char_we    <= 1'b1;
                  char_addr  <= {next_row, 7'd0};
                  char_value <= BLANK_VALUE;
                end

                8'h08: begin
                  // Backspace at column 0 does nothing.
                  if (cursor_col != 7'd0) begin
                    cursor_col          <= cursor_col - 7'd1;
                    state               <= WRITE;
                    in_ready            <= 1'b0;
                    advance_after_write <= 1'b0;
                    char_we             <= 1'b1;
                    char_addr           <= {cursor_row, cursor_col - 7'd1};
                    char_value          <= BLANK_VALUE;
                  end
                end

                8'h0C: begin
                  cursor_col <= '0;
                  cursor_row <= '0;
                  state      <= CLR_SCREEN;
                  in_ready   <= 1'b0;
                  busy       <= 1'b1;
                  char_we    <= 1'b1;
                  char_addr  <= '0;
                  char_value <= BLANK_VALUE;
                end

                default: begin
                  // Other codes are consumed and ignored.
                end
              endcase
            end
          end
        end

        WRITE: begin
          if (advance_after_write && cursor_col == LAST_COL) begin
            // The cursor wraps to a new row, so blank that row first.
            cursor_col <= '0;
            cursor_row <= next_row;
            state      <= CLR_LINE;
            busy       <= 1'b1;
            char_we    <= 1'b1;
            char_addr  <= {next_row, 7'd0};
            char_value <= BLANK_VALUE;
          end else begin
            if (advance_after_write) begin
              cursor_col <= cursor_col + 7'd1;
            end
            state    <= IDLE;
            in_ready <= 1'b1;
          end
        end

        CLR_LINE: begin
          if (addr_col == LAST_COL) begin
            state    <= IDLE;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            char_we   <= 1'b1;
            char_addr <= {addr_row, addr_col + 7'd1};
          end
        end

        CLR_SCREEN: begin
          if (addr_col == LAST_COL) begin
            if (addr_row == LAST_ROW) begin
              state    <= IDLE;
              busy     <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              char_we   <= 1'b1;
              char_addr <= {addr_row + 5'd1, 7'd0};
            end
          end else begin
            char_we   <= 1'b1;
            char_addr <= {addr_row, addr_col + 7'd1};
          end
        end

        default: begin
          // Unreachable encodings restart the power-up sequence.
          state    <= RESET_WAIT;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_console_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_console_writer
//
// Directed testbench for vga_console_writer with the default parameters
// (80x30, clear on reset, blank 0x20). Inputs change and outputs are sampled
// on the falling edge. Character-memory writes are captured into queues so
// each scenario can check the full write sequence it expects.
// ---------------------------------------------------------------------------
module tb_vga_console_writer;

  logic        clk_data;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_char;
  logic        in_ready;
  logic        char_we;
  logic [11:0] char_addr;
  logic [31:0] char_value;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks   = 0;
  int errors   = 0;
  int timeouts = 0;

  logic [11:0] q_addr[$];
  logic [31:0] q_val[$];
  logic        q_busy[$];

  vga_console_writer dut (
    .clk_data   (clk_data),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .char_we    (char_we),
    .char_addr  (char_addr),
    .char_value (char_value),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk_data = 1'b0;
  always #5 clk_data = ~clk_data;

  function automatic logic [11:0] addr_of(input int row, input int col);
    return {5'(row), 7'(col)};
  endfunction

  // Starting at a falling edge, record every write until in_ready is seen or
  // the cycle budget runs out.
  task automatic collect(input int budget);
    bit done;
    done = 1'b0;
    q_addr.delete();
    q_val.delete();
    q_busy.delete();
    for (int i = 0; i < budget; i++) begin
      if (char_we) begin
        q_addr.push_back(char_addr);
        q_val.push_back(char_value);
        q_busy.push_back(busy);
      end
      if (in_ready) begin
        done = 1'b1;
        break;
      end
      @(negedge clk_data);
    end
    if (!done) timeouts++;
  endtask

  // Present one byte for one cycle. The caller must already be at a falling
  // edge with in_ready high. The task returns at the first falling edge after
  // the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_char  = b;
    @(negedge clk_data);
    in_valid = 1'b0;
  endtask

  task automatic type_byte(input logic [7:0] b);
    send_byte(b);
    collect(300);
  endtask

  task automatic test_reset;
    int bad;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    repeat (2) @(negedge clk_data);
    checks++;
    if ({char_we, char_addr, char_value, cursor_col, cursor_row, in_ready, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: we=%0b addr=%h val=%h col=%0d row=%0d rdy=%0b busy=%0b, required all zero",
               char_we, char_addr, char_value, cursor_col, cursor_row, in_ready, busy);
    end
    rst_n = 1'b1;
    collect(3000);
    checks++;
    if (q_addr.size() != 2400) begin
      errors++;
      $display("FAIL reset_clear_count: got %0d writes, required 2400", q_addr.size());
    end
    bad = 0;
    foreach (q_addr[i]) begin
      if (q_addr[i] !== addr_of(i / 80, i % 80) || q_val[i] !== 32'h20 || q_busy[i] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_clear_sequence: %0d bad entries, required 0", bad);
    end
    checks++;
    if (q_addr.size() > 0 && (q_addr[0] !== 12'h000 || q_addr[q_addr.size()-1] !== addr_of(29, 79))) begin
      errors++;
      $display("FAIL reset_clear_ends: first=%h last=%h, required 000 and %h",
               q_addr[0], q_addr[q_addr.size()-1], addr_of(29, 79));
    end
    checks++;
    if ({in_ready, busy, cursor_col, cursor_row} !== {1'b1, 1'b0, 7'd0, 5'd0}) begin
      errors++;
      $display("FAIL reset_clear_done: rdy=%0b busy=%0b col=%0d row=%0d, required 1 0 0 0",
               in_ready, busy, cursor_col, cursor_row);
    end
  endtask

  task automatic test_back_to_back;
    in_valid = 1'b1;
    in_char  = 8'h48;
    @(negedge clk_data);
    checks++;
    if ({char_we, char_addr, char_value, in_ready} !== {1'b1, 12'h000, 32'h48, 1'b0}) begin
      errors++;
      $display("FAIL b2b_first: we=%0b addr=%h val=%h rdy=%0b, required 1 000 00000048 0",
               char_we, char_addr, char_value, in_ready);
    end
    in_char = 8'h69;
    @(negedge clk_data);
    checks++;
    if ({char_we, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_gap: we=%0b rdy=%0b, required 0 1", char_we, in_ready);
    end
    @(negedge clk_data);
    in_valid = 1'b0;
    checks++;
    if ({char_we, char_addr, char_value, in_ready} !== {1'b1, 12'h001, 32'h69, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: we=%0b addr=%h val=%h rdy=%0b, required 1 001 00000069 0",
               char_we, char_addr, char_value, in_ready);
    end
    @(negedge clk_data);
    checks++;
    if ({cursor_col, cursor_row, in_ready} !== {7'd2, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_cursor: col=%0d row=%0d rdy=%0b, required 2 0 1", cursor_col, cursor_row, in_ready);
    end
  endtask

  task automatic test_wrap;
    int bad;
    for (int i = 2; i < 79; i++) type_byte(8'h2E);
    checks++;
    if ({cursor_col, cursor_row} !== {7'd79, 5'd0}) begin
      errors++;
      $display("FAIL wrap_setup: col=%0d row=%0d, required 79 0", cursor_col, cursor_row);
    end
    send_byte(8'h41);
    // Hold a byte while the line clear runs. It must wait for IDLE.
    in_valid = 1'b1;
    in_char  = 8'h5A;
    collect(300);
    checks++;
    if (q_addr.size() != 81 || q_addr[0] !== 12'h04F || q_val[0] !== 32'h41) begin
      errors++;
      $display("FAIL wrap_write: n=%0d first addr=%h val=%h, required 81 04F 00000041",
               q_addr.size(), q_addr[0], q_val[0]);
    end
    bad = 0;
    for (int i = 1; i < q_addr.size(); i++) begin
      if (q_addr[i] !== addr_of(1, i - 1) || q_val[i] !== 32'h20 || q_busy[i] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_line_clear: %0d bad entries, required 0", bad);
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd0, 5'd1}) begin
      errors++;
      $display("FAIL wrap_cursor: col=%0d row=%0d, required 0 1", cursor_col, cursor_row);
    end
    @(negedge clk_data);
    in_valid = 1'b0;
    checks++;
    if ({char_we, char_addr, char_value} !== {1'b1, 12'h080, 32'h5A}) begin
      errors++;
      $display("FAIL held_byte: we=%0b addr=%h val=%h, required 1 080 0000005A", char_we, char_addr, char_value);
    end
    collect(300);
  endtask

  task automatic test_newline_cr;
    int bad;
    for (int i = 0; i < 28; i++) type_byte(8'h0A);
    for (int i = 0; i < 5; i++) type_byte(8'h61 + 8'(i));
    checks++;
    if ({cursor_col, cursor_row} !== {7'd5, 5'd29}) begin
      errors++;
      $display("FAIL lf_setup: col=%0d row=%0d, required 5 29", cursor_col, cursor_row);
    end
    send_byte(8'h0A);
    collect(300);
    bad = 0;
    foreach (q_addr[i]) begin
      if (q_addr[i] !== addr_of(0, i) || q_val[i] !== 32'h20 || q_busy[i] !== 1'b1) bad++;
    end
    checks++;
    if (q_addr.size() != 80 || bad != 0) begin
      errors++;
      $display("FAIL lf_row_wrap_clear: n=%0d bad=%0d, required 80 0", q_addr.size(), bad);
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd0, 5'd0}) begin
      errors++;
      $display("FAIL lf_cursor: col=%0d row=%0d, required 0 0", cursor_col, cursor_row);
    end
    send_byte(8'h0D);
    checks++;
    if ({char_we, in_ready, cursor_col} !== {1'b0, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL cr_col0: we=%0b rdy=%0b col=%0d, required 0 1 0", char_we, in_ready, cursor_col);
    end
    type_byte(8'h78);
    type_byte(8'h79);
    send_byte(8'h0D);
    checks++;
    if ({char_we, in_ready, cursor_col, cursor_row} !== {1'b0, 1'b1, 7'd0, 5'd0}) begin
      errors++;
      $display("FAIL cr_col2: we=%0b rdy=%0b col=%0d row=%0d, required 0 1 0 0",
               char_we, in_ready, cursor_col, cursor_row);
    end
  endtask

  task automatic test_backspace_ignore;
    type_byte(8'h0A);
    type_byte(8'h0A);
    for (int i = 0; i < 3; i++) type_byte(8'h30);
    send_byte(8'h08);
    checks++;
    if ({char_we, char_addr, char_value, cursor_col, in_ready} !== {1'b1, 12'h102, 32'h20, 7'd2, 1'b0}) begin
      errors++;
      $display("FAIL bs_write: we=%0b addr=%h val=%h col=%0d rdy=%0b, required 1 102 00000020 2 0",
               char_we, char_addr, char_value, cursor_col, in_ready);
    end
    collect(300);
    checks++;
    if ({cursor_col, cursor_row, q_addr.size()} !== {7'd2, 5'd2, 32'd1}) begin
      errors++;
      $display("FAIL bs_cursor: col=%0d row=%0d writes=%0d, required 2 2 1", cursor_col, cursor_row, q_addr.size());
    end
    type_byte(8'h0D);
    send_byte(8'h08);
    checks++;
    if ({char_we, in_ready, cursor_col} !== {1'b0, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL bs_col0: we=%0b rdy=%0b col=%0d, required 0 1 0", char_we, in_ready, cursor_col);
    end
    send_byte(8'h07);
    checks++;
    if ({char_we, in_ready, busy, cursor_col, cursor_row} !== {1'b0, 1'b1, 1'b0, 7'd0, 5'd2}) begin
      errors++;
      $display("FAIL ignore_bel: we=%0b rdy=%0b busy=%0b col=%0d row=%0d, required 0 1 0 0 2",
               char_we, in_ready, busy, cursor_col, cursor_row);
    end
  endtask

  task automatic test_ff_reset;
    int n;
    int bad;
    type_byte(8'h31);
    send_byte(8'h0C);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (char_we) n++;
      if (n == 100) break;
      @(negedge clk_data);
    end
    checks++;
    if (n != 100 || char_addr !== addr_of(1, 19) || busy !== 1'b1) begin
      errors++;
      $display("FAIL ff_progress: writes=%0d addr=%h busy=%0b, required 100 %h 1", n, char_addr, addr_of(1, 19), busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({char_we, char_addr, busy, in_ready} !== {1'b0, 12'h000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: we=%0b addr=%h busy=%0b rdy=%0b, required 0 000 0 0",
               char_we, char_addr, busy, in_ready);
    end
    @(negedge clk_data);
    rst_n = 1'b1;
    collect(3000);
    bad = 0;
    foreach (q_addr[i]) begin
      if (q_addr[i] !== addr_of(i / 80, i % 80) || q_val[i] !== 32'h20) bad++;
    end
    checks++;
    if (q_addr.size() != 2400 || bad != 0) begin
      errors++;
      $display("FAIL restart_clear: n=%0d bad=%0d, required 2400 0", q_addr.size(), bad);
    end
    checks++;
    if ({cursor_col, cursor_row, in_ready} !== {7'd0, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL restart_cursor: col=%0d row=%0d rdy=%0b, required 0 0 1", cursor_col, cursor_row, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wrap();
    test_newline_cr();
    test_backspace_ignore();
    test_ff_reset();
    checks++;
    if (timeouts != 0) begin
      errors++;
      $display("FAIL wait_budget: %0d waits expired, required 0", timeouts);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
